// File: rtl/pc_seq_ctrl_pkg.sv
// Shared definitions for the PC sequencing controller: FSM state encoding,
// the opcodes that steer the next-PC muxes, and the mux select values.
// Optional macro FETCH_TIMEOUT_EN adds the RETRY state.
package pc_seq_ctrl_pkg;

  localparam logic [2:0] ST_RST_ENC   = 3'd0;
  localparam logic [2:0] ST_FETCH_ENC = 3'd1;
  localparam logic [2:0] ST_EXEC_ENC  = 3'd2;
  localparam logic [2:0] ST_HALT_ENC  = 3'd3;
  localparam logic [2:0] ST_RETRY_ENC = 3'd4;

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_RST   = ST_RST_ENC,
    S_FETCH = ST_FETCH_ENC,
    S_EXEC  = ST_EXEC_ENC,
    S_HALT  = ST_HALT_ENC,
    S_RETRY = ST_RETRY_ENC
  } state_t;
`else
  typedef enum logic [2:0] {
    S_RST   = ST_RST_ENC,
    S_FETCH = ST_FETCH_ENC,
    S_EXEC  = ST_EXEC_ENC,
    S_HALT  = ST_HALT_ENC
  } state_t;
`endif

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // PC_sel: PC+increment vs register target; INC_sel: offset vs constant 4
  localparam logic SEL_INC = 1'b1;
  localparam logic SEL_RA  = 1'b0;
  localparam logic INC_OFF = 1'b1;
  localparam logic INC_4   = 1'b0;

endpackage

// File: rtl/pc_seq_ctrl_next_pc_sel_dec.sv
// Purely combinational next-PC source decoder: opcode and branch outcome
// to PC/increment mux selects. Kept separate so a pipelined front end can
// reuse it directly.
module next_pc_sel_dec
  import pc_seq_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       br_taken,
  output logic       pc_sel,
  output logic       inc_sel
);

  // JAL and taken branches add the offset; JALR jumps to the register target
  always_comb begin
    pc_sel  = SEL_INC;
    inc_sel = INC_4;
    if (opcode == OP_JAL) begin
      inc_sel = INC_OFF;
    end else if (opcode == OP_JALR) begin
      pc_sel = SEL_RA;
    end else if ((opcode == OP_BRANCH) && br_taken) begin
      inc_sel = INC_OFF;
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch/execute sequencer for the instruction-address datapath.
// Optional macro FETCH_TIMEOUT_EN: bounded fetch wait with fetch_err pulse
// and a one-cycle RETRY that drops the request before refetching.
//
// state | meaning
// RST   | reset landing state, all strobes idle
// FETCH | imem_req high, waiting for imem_rdy
// EXEC  | instruction executing; PC updated on the first non-stall cycle
// HALT  | stopped after retirement while halt_req stays high
// RETRY | request dropped for one cycle after a fetch timeout
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_rdy,
  output logic             ir_load,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             stall,
  input  logic             halt_req,
  output logic             ex_valid,
  output logic             PC_en,
  output logic             PC_sel,
  output logic             INC_sel,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retire_cnt
);

  state_t state;
  state_t state_nxt;
  logic   dec_pc_sel;
  logic   dec_inc_sel;
  logic   to_hit;

  next_pc_sel_dec u_dec (
    .opcode   (opcode),
    .br_taken (br_taken),
    .pc_sel   (dec_pc_sel),
    .inc_sel  (dec_inc_sel)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  // Fetch wait counter: counts unready FETCH cycles, cleared whenever we leave FETCH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if ((state == S_FETCH) && !imem_rdy) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  // This unready cycle is the one that brings the count to TIMEOUT
  assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Mealy outputs
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    ex_valid  = 1'b0;
    PC_en     = 1'b0;
    PC_sel    = SEL_INC;
    INC_sel   = INC_4;
    halted    = 1'b0;
    fetch_err = 1'b0;
    case (state)
      S_RST: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          ir_load   = 1'b1;
          state_nxt = S_EXEC;
        end else if (to_hit) begin
          fetch_err = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          state_nxt = S_RETRY;
`endif
        end
      end
      S_EXEC: begin
        ex_valid = 1'b1;
        if (!stall) begin
          PC_en     = 1'b1;
          PC_sel    = dec_pc_sel;
          INC_sel   = (dec_pc_sel == SEL_RA) ? INC_4 : dec_inc_sel;
          state_nxt = halt_req ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt_req) begin
          state_nxt = S_FETCH;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      S_RETRY: begin
        state_nxt = S_FETCH;
      end
`endif
      default: begin
        state_nxt = S_RST;
      end
    endcase
  end

  // Retired-instruction counter, bumped on each PC update; wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (PC_en) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl with a behavioural PC register driven
// from the DUT mux selects. Inputs change and outputs are checked just
// after the falling edge.
module tb_pc_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic        imem_rdy;
  logic        ir_load;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        stall;
  logic        halt_req;
  logic        ex_valid;
  logic        PC_en;
  logic        PC_sel;
  logic        INC_sel;
  logic        halted;
  logic        fetch_err;
  logic [31:0] retire_cnt;

  logic [31:0] pc;
  logic [31:0] ra;
  logic [31:0] offset;

  int n_chk;
  int n_pass;

  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] JAL  = 7'b1101111;

  pc_seq_ctrl #(.CNT_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_rdy   (imem_rdy),
    .ir_load    (ir_load),
    .opcode     (opcode),
    .br_taken   (br_taken),
    .stall      (stall),
    .halt_req   (halt_req),
    .ex_valid   (ex_valid),
    .PC_en      (PC_en),
    .PC_sel     (PC_sel),
    .INC_sel    (INC_sel),
    .halted     (halted),
    .fetch_err  (fetch_err),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model fed by the DUT's enable and mux selects
  always @(posedge clk) begin
    if (!rst_n) pc <= 32'd0;
    else if (PC_en) pc <= PC_sel ? (pc + (INC_sel ? offset : 32'd4)) : ra;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; imem_rdy = 1'b0; opcode = ADDI; br_taken = 1'b0;
    stall = 1'b0; halt_req = 1'b0; ra = 32'd100; offset = 32'd0;

    // reset state
    tick(); tick(); #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc_sel", PC_sel, 1);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_retire", retire_cnt, 0);

    // release: one RST cycle, then fetch/exec alternate with ready held high
    rst_n = 1'b1; imem_rdy = 1'b1;
    #1 chk("rel_rst_req", imem_req, 0);
    tick(); #1;
    chk("f1_req", imem_req, 1);
    chk("f1_irload", ir_load, 1);
    chk("f1_pcen", PC_en, 0);
    tick(); #1;
    chk("e1_exvalid", ex_valid, 1);
    chk("e1_pcen", PC_en, 1);
    chk("e1_incsel", INC_sel, 0);
    chk("e1_irload", ir_load, 0);
    chk("pc0", pc, 0);
    tick(); #1;
    chk("f2_irload", ir_load, 1);
    chk("pc4", pc, 4);
    tick(); #1;
    chk("e2_pcen", PC_en, 1);
    tick(); #1;
    chk("pc8", pc, 8);
    chk("retire2", retire_cnt, 2);

    // taken branch, offset -8
    tick(); opcode = BR; br_taken = 1'b1; offset = 32'hFFFF_FFF8; #1;
    chk("brt_pcen", PC_en, 1);
    chk("brt_pcsel", PC_sel, 1);
    chk("brt_incsel", INC_sel, 1);
    tick(); opcode = ADDI; #1;
    chk("brt_pc", pc, 0);
    chk("brt_retire", retire_cnt, 3);

    // not-taken branch
    tick(); opcode = BR; br_taken = 1'b0; #1;
    chk("brn_pcen", PC_en, 1);
    chk("brn_incsel", INC_sel, 0);
    tick(); #1;
    chk("brn_pc", pc, 4);
    chk("brn_retire", retire_cnt, 4);

    // JALR with three stall cycles
    for (int i = 0; i < 3; i++) begin
      tick(); opcode = JALR; stall = 1'b1; #1;
      chk("jalr_stall_exvalid", ex_valid, 1);
      chk("jalr_stall_pcen", PC_en, 0);
    end
    tick(); stall = 1'b0; #1;
    chk("jalr_exvalid", ex_valid, 1);
    chk("jalr_pcen", PC_en, 1);
    chk("jalr_pcsel", PC_sel, 0);
    chk("jalr_incsel", INC_sel, 0);
    tick(); opcode = ADDI; #1;
    chk("jalr_pc", pc, 100);
    chk("jalr_retire", retire_cnt, 5);

    // JAL with offset 16
    tick(); opcode = JAL; offset = 32'd16; #1;
    chk("jal_pcsel", PC_sel, 1);
    chk("jal_incsel", INC_sel, 1);
    tick(); opcode = ADDI; imem_rdy = 1'b0; halt_req = 1'b1; #1;
    chk("jal_pc", pc, 116);

    // halt requested during FETCH: fetch still completes
    chk("hf_req", imem_req, 1);
    chk("hf_irload", ir_load, 0);
    tick(); imem_rdy = 1'b1; #1;
    chk("hf_irload2", ir_load, 1);
    tick(); #1;
    chk("he_pcen", PC_en, 1);
    tick(); #1;
    chk("h_halted", halted, 1);
    chk("h_req", imem_req, 0);
    chk("h_pcsel", PC_sel, 1);
    chk("h_retire", retire_cnt, 7);
    tick(); halt_req = 1'b0; #1;
    chk("h_still", halted, 1);
    tick(); imem_rdy = 1'b0; #1;
    chk("hx_req", imem_req, 1);
    chk("hx_halted", halted, 0);

    // reset in the middle of a fetch
    tick(); rst_n = 1'b0; #1;
    tick(); imem_rdy = 1'b1; #1;
    chk("mrst_req", imem_req, 0);
    chk("mrst_retire", retire_cnt, 0);
    chk("mrst_irload", ir_load, 0);
    tick(); rst_n = 1'b1; imem_rdy = 1'b0; #1;

`ifdef FETCH_TIMEOUT_EN
    // TIMEOUT=4: error on 4th unready cycle, one RETRY cycle, then refetch
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("to_wait_err", fetch_err, 0);
      chk("to_wait_req", imem_req, 1);
    end
    tick(); #1;
    chk("to_err", fetch_err, 1);
    tick(); #1;
    chk("retry_req", imem_req, 0);
    chk("retry_err", fetch_err, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("rf_wait_req", imem_req, 1);
      chk("rf_wait_err", fetch_err, 0);
    end
    tick(); imem_rdy = 1'b1; #1;
    chk("rf_irload", ir_load, 1);
    chk("rf_noerr", fetch_err, 0);
`else
    // without the timeout feature a fetch waits indefinitely
    begin
      int err_seen;
      int req_drop;
      err_seen = 0; req_drop = 0;
      for (int i = 0; i < 70; i++) begin
        tick(); #1;
        if (fetch_err !== 1'b0) err_seen++;
        if (imem_req !== 1'b1) req_drop++;
      end
      chk("wait_err_cycles", err_seen, 0);
      chk("wait_req_drops", req_drop, 0);
    end
    tick(); imem_rdy = 1'b1; #1;
    chk("wait_irload", ir_load, 1);
    chk("wait_noerr", fetch_err, 0);
`endif
    tick(); #1;
    chk("final_pcen", PC_en, 1);
    tick(); #1;
    chk("final_retire", retire_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
